// File: rtl/alu_flag_cond_if.sv
// alu_flag_cond_if: instruction/flag bundle between decode/ALU and the flag-condition unit
interface alu_flag_cond_if;
  logic       valid_i;
  logic       stall_i;
  logic       flush_i;
  logic [3:0] cond_i;
  logic [1:0] flag_write_i;
  logic [3:0] alu_flags_i;
  logic       reg_write_i;
  logic       mem_write_i;
  logic       pc_src_i;
  logic [3:0] flags_o;
  logic       valid_o;
  logic       cond_ex_o;
  logic       reg_write_o;
  logic       mem_write_o;
  logic       pc_src_o;
  modport master (
    output valid_i, stall_i, flush_i, cond_i, flag_write_i, alu_flags_i,
           reg_write_i, mem_write_i, pc_src_i,
    input  flags_o, valid_o, cond_ex_o, reg_write_o, mem_write_o, pc_src_o
  );
  modport slave (
    input  valid_i, stall_i, flush_i, cond_i, flag_write_i, alu_flags_i,
           reg_write_i, mem_write_i, pc_src_i,
    output flags_o, valid_o, cond_ex_o, reg_write_o, mem_write_o, pc_src_o
  );
endinterface

// File: rtl/alu_flag_cond_unit.sv
// alu_flag_cond_unit: NZCV flag register, condition evaluation and gated writeback enables
module alu_flag_cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input logic            clk,
  input logic            reset,
  alu_flag_cond_if.slave bus
);
  logic [3:0]  flags;
  logic        n, z, c, v, cond_ex, issue, pass;
  logic [15:0] cond_tbl;
  assign {n, z, c, v} = flags;
  // Entry k holds the outcome of condition code k against the current flags
  assign cond_tbl = {1'b1, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z,
                     ~v, v, ~n, n, ~c, c, ~z, z};
  assign cond_ex = cond_tbl[bus.cond_i];
  assign issue = bus.valid_i & ~bus.stall_i & ~bus.flush_i;
  assign pass = issue & cond_ex;
  assign bus.flags_o = flags;
  always_ff @(posedge clk) begin
    if (reset) flags <= RESET_FLAGS;
    else if (pass) flags <= {bus.flag_write_i[1] ? bus.alu_flags_i[3:2] : flags[3:2],
                             bus.flag_write_i[0] ? bus.alu_flags_i[1:0] : flags[1:0]};
  end
  // Flush overrides stall so a killed instruction never lingers in the output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.valid_o     <= 1'b0;
      bus.cond_ex_o   <= 1'b0;
      bus.reg_write_o <= 1'b0;
      bus.mem_write_o <= 1'b0;
      bus.pc_src_o    <= 1'b0;
    end else if (!bus.stall_i || bus.flush_i) begin
      bus.valid_o     <= issue;
      bus.cond_ex_o   <= pass;
      bus.reg_write_o <= pass & bus.reg_write_i;
      bus.mem_write_o <= pass & bus.mem_write_i;
      bus.pc_src_o    <= pass & bus.pc_src_i;
    end
  end
endmodule

// File: tb/tb_alu_flag_cond_unit.sv
// tb_alu_flag_cond_unit: randomized + directed scoreboard bench for alu_flag_cond_unit
module tb_alu_flag_cond_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  alu_flag_cond_if bus ();
  alu_flag_cond_if bus2 ();
  alu_flag_cond_unit u_dut (.clk(clk), .reset(reset), .bus(bus));
  alu_flag_cond_unit #(.RESET_FLAGS(4'b0100)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
  logic [8:0] q[$];
  logic [3:0] mf;
  logic [4:0] mo;
  function automatic logic cond_ok(input logic [3:0] cd, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cd)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return c;
      4'd3: return !c;
      4'd4: return n;
      4'd5: return !n;
      4'd6: return v;
      4'd7: return !v;
      4'd8: return c && !z;
      4'd9: return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction
  task automatic step(input logic r, input logic vl, input logic st, input logic fl,
                      input logic [3:0] cd, input logic [1:0] fw, input logic [3:0] a,
                      input logic rw, input logic mw, input logic pc);
    logic iss, ps;
    @(posedge clk);
    #2;
    reset = r;
    bus.valid_i = vl; bus.stall_i = st; bus.flush_i = fl; bus.cond_i = cd;
    bus.flag_write_i = fw; bus.alu_flags_i = a;
    bus.reg_write_i = rw; bus.mem_write_i = mw; bus.pc_src_i = pc;
    if (r) begin
      mf = 4'b0000;
      mo = 5'b0;
    end else begin
      iss = vl && !st && !fl;
      ps = iss && cond_ok(cd, mf);
      if (fl || !st) mo = {iss, ps, ps & rw, ps & mw, ps & pc};
      if (ps) begin
        if (fw[1]) mf[3:2] = a[3:2];
        if (fw[0]) mf[1:0] = a[1:0];
      end
    end
    q.push_back({mf, mo});
  endtask
  task automatic go(input logic [3:0] cd, input logic [1:0] fw, input logic [3:0] a,
                    input logic rw, input logic mw, input logic pc);
    step(1'b0, 1'b1, 1'b0, 1'b0, cd, fw, a, rw, mw, pc);
  endtask
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.flags_o !== e[8:5]) begin
          errors++;
          $display("FAIL flags t=%0t got=%b exp=%b", $time, bus.flags_o, e[8:5]);
        end
        checks++;
        if ({bus.valid_o, bus.cond_ex_o, bus.reg_write_o, bus.mem_write_o, bus.pc_src_o} !== e[4:0]) begin
          errors++;
          $display("FAIL outs(v,cex,rw,mw,pc) t=%0t got=%b exp=%b", $time,
                   {bus.valid_o, bus.cond_ex_o, bus.reg_write_o, bus.mem_write_o, bus.pc_src_o}, e[4:0]);
        end
      end
    end
  end
  initial begin
    reset = 1'b1;
    bus.valid_i = 0; bus.stall_i = 0; bus.flush_i = 0; bus.cond_i = 0; bus.flag_write_i = 0;
    bus.alu_flags_i = 0; bus.reg_write_i = 0; bus.mem_write_i = 0; bus.pc_src_i = 0;
    bus2.valid_i = 0; bus2.stall_i = 0; bus2.flush_i = 0; bus2.cond_i = 0; bus2.flag_write_i = 0;
    bus2.alu_flags_i = 0; bus2.reg_write_i = 0; bus2.mem_write_i = 0; bus2.pc_src_i = 0;
    mf = 4'b0; mo = 5'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'he, 2'b11, 4'hf, 1, 1, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 4'h0, 0, 0, 0);
    checks++;
    if (u_dut2.bus.flags_o !== 4'b0100) begin
      errors++;
      $display("FAIL reset_flags_param got=%b exp=0100", u_dut2.bus.flags_o);
    end
    go(4'he, 2'b11, 4'b0100, 1, 0, 0);
    go(4'h0, 2'b00, 4'b0000, 1, 0, 1);
    go(4'h1, 2'b11, 4'b1010, 0, 1, 0);
    go(4'he, 2'b11, 4'b1100, 0, 0, 0);
    go(4'he, 2'b01, 4'b0011, 0, 0, 0);
    go(4'he, 2'b10, 4'b0000, 0, 0, 0);
    for (int f = 0; f < 16; f++)
      for (int c = 0; c < 16; c++) begin
        go(4'he, 2'b11, 4'(f), 0, 0, 0);
        go(4'(c), 2'b00, 4'h0, 1, 1, 1);
      end
    go(4'he, 2'b11, 4'b0110, 1, 1, 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'he, 2'b11, 4'b1001, 1, 1, 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'he, 2'b11, 4'b1001, 1, 1, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'he, 2'b11, 4'b1001, 1, 1, 1);
    go(4'he, 2'b11, 4'b1001, 1, 0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'he, 2'b11, 4'b0000, 1, 1, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'he, 2'b11, 4'b0000, 1, 1, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'he, 2'b11, 4'b0000, 1, 1, 1);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 1, 4'($urandom), 2'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
